cache_controller: RTL and testbench
===================================

# cache_controller

Sequencing FSM for the direct-mapped, write-through, no-write-allocate data cache in the RISC-V core. It consumes the MemRead/MemWrite strobes produced by the main decoder and the cache array's hit signal. It stalls the pipeline, drives the main-memory read/write handshake, and steps the multi-word block refill into the cache data array.

## Interface
- BLOCK_WORDS, 4: words per cache block; power of two, ≥2.
- CNT_W, 16: width of statistics counters (CACHE_STATS_EN only).

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MemRead  in  1  load in current instruction (main decoder).
- MemWrite  in  1  store in current instruction (main decoder).
- hit  in  1  valid & tag match for the current address (combinational, from cache array).
- mem_ready  in  1  main memory completes the current word transfer this cycle.
- stall  out  1  freeze PC and pipeline registers.
- mem_rd  out  1  main-memory word read request.
- mem_wr  out  1  main-memory word write request.
- cache_we  out  1  write one word into the cache data array.
- cache_valid_set  out  1  write tag and set valid bit for the current line.
- word_idx  out  $clog2(BLOCK_WORDS)  block word offset for refill reads and cache_we.
- hit_cnt, miss_cnt  out  CNT_W each  load hit/miss counters (CACHE_STATS_EN only).

## Operation
- States: IDLE, REFILL, WRITE, DONE; 2-bit encoding, IDLE = 0.
- IDLE behaviour:
  - MemWrite: stall=1. Latch hit into hit_q. Next state WRITE. MemWrite has priority if both strobes are high.
  - MemRead & hit: stall=0. Stay in IDLE (zero-penalty hit).
  - MemRead & ~hit: stall=1. Clear word_idx. Next state REFILL.
  - Otherwise: all outputs 0.
- REFILL: stall=1, mem_rd=1, word_idx drives the address offset.
  - Each cycle with mem_ready=1: cache_we=1 and word_idx increments.
  - When mem_ready=1 with word_idx==BLOCK_WORDS-1: also cache_valid_set=1. word_idx wraps to 0. Next state DONE.
  - mem_ready=0: hold all state.
- WRITE: stall=1, mem_wr=1.
  - On mem_ready=1: cache_we=hit_q (update on write hit only; no allocate on miss). Next state DONE.
- DONE: stall=0 for exactly one cycle, so the held instruction retires (a load now hits). MemRead and MemWrite are ignored. Next state IDLE.
- All outputs are combinational from state and inputs. word_idx and hit_q are registered.

## Timing
- Reset (async, rst_n=0):
  - State IDLE, word_idx=0, hit_q=0, counters=0.
  - stall, mem_rd, mem_wr, cache_we and cache_valid_set are 0 while MemRead=MemWrite=0.
  - Reset mid-REFILL/WRITE abandons the transfer. The line is left invalid because cache_valid_set never fired.
- Load hit: 0 stall cycles.
- Load miss, mem_ready with N wait cycles per word: stall = 1 + BLOCK_WORDS·(N+1) cycles. Retires in the DONE cycle.
- Store: stall = 2 + N cycles.
- mem_rd/mem_wr stay high continuously until the accepting mem_ready. They are never high in IDLE or DONE.
- A back-to-back memory instruction after DONE is evaluated normally in the following IDLE cycle.

## Configuration
- CACHE_STATS_EN defined: hit_cnt and miss_cnt ports and registers exist.
  - hit_cnt increments on IDLE & MemRead & hit & ~MemWrite.
  - miss_cnt increments on the IDLE→REFILL transition.
  - Both saturate at 2^CNT_W-1 and are not incremented in DONE.
- CACHE_STATS_EN undefined: both counters and ports are omitted. FSM behaviour is identical.

## Test plan
- Reset, then MemRead=1, hit=1 → stall=0 every cycle; mem_rd never asserted; hit_cnt=1.
- MemRead=1, hit=0, mem_ready tied 1, BLOCK_WORDS=4 → stall high 5 cycles; cache_we pulses with word_idx 0,1,2,3; cache_valid_set on word 3; DONE stall=0; miss_cnt=1.
- Read miss with mem_ready high every 3rd cycle → exactly 13 stall cycles; word_idx holds between readies.
- MemWrite=1, hit=1, mem_ready after 2 waits → mem_wr high 3 cycles; cache_we=1 on the ready cycle; 4 stall cycles total.
- MemWrite=1, hit=0 → cache_we stays 0 throughout; mem_wr handshake completes; returns to IDLE.
- rst_n low during REFILL word 2 → immediate IDLE, stall=0, word_idx=0, no cache_valid_set; the next MemRead miss restarts refill at word 0.

Source files
------------

// File: rtl/cache_controller.sv
// cache_controller: sequencing FSM for a direct-mapped, write-through,
// no-write-allocate data cache. Stalls the pipeline on load misses and
// stores, runs the main-memory word handshake and steps the block refill.
// Optional feature macro: CACHE_STATS_EN adds saturating load hit/miss
// counters and their hit_cnt/miss_cnt ports.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transfer; loads that hit retire with zero penalty
// REFILL | reading BLOCK_WORDS words from memory into the data array
// WRITE  | single-word write-through to memory (array updated on hit)
// DONE   | one unstalled cycle so the held instruction retires
module cache_controller #(
  parameter int BLOCK_WORDS = 4,
  parameter int CNT_W       = 16,
  localparam int IDX_W      = $clog2(BLOCK_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             hit,
  input  logic             mem_ready,
  output logic             stall,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             cache_we,
  output logic             cache_valid_set,
`ifdef CACHE_STATS_EN
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
`endif
  output logic [IDX_W-1:0] word_idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_word_idx;
  logic             r_hit_q;
  logic             w_last_word;
  logic             w_miss_start;
  logic             w_load_hit;
  logic             w_store_start;

  assign w_last_word   = (r_word_idx == IDX_W'(BLOCK_WORDS - 1));
  assign w_store_start = (r_state == IDLE) && MemWrite;
  assign w_miss_start  = (r_state == IDLE) && MemRead && !hit && !MemWrite;
  assign w_load_hit    = (r_state == IDLE) && MemRead && hit && !MemWrite;
  assign word_idx      = r_word_idx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and combinational outputs
  always_comb begin
    w_next          = r_state;
    stall           = 1'b0;
    mem_rd          = 1'b0;
    mem_wr          = 1'b0;
    cache_we        = 1'b0;
    cache_valid_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (MemWrite) begin
          stall  = 1'b1;
          w_next = WRITE;
        end else if (MemRead && !hit) begin
          stall  = 1'b1;
          w_next = REFILL;
        end
      end
      REFILL: begin
        stall  = 1'b1;
        mem_rd = 1'b1;
        if (mem_ready) begin
          cache_we = 1'b1;
          if (w_last_word) begin
            cache_valid_set = 1'b1;
            w_next          = DONE;
          end
        end
      end
      WRITE: begin
        stall  = 1'b1;
        mem_wr = 1'b1;
        if (mem_ready) begin
          cache_we = r_hit_q;
          w_next   = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Refill word pointer; wraps to 0 naturally after the last word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_word_idx <= '0;
    else if (w_miss_start)
      r_word_idx <= '0;
    else if (r_state == REFILL && mem_ready)
      r_word_idx <= r_word_idx + IDX_W'(1);
  end

  // Remember whether the store hit so the array is only updated on a hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_hit_q <= 1'b0;
    else if (w_store_start) r_hit_q <= hit;
  end

`ifdef CACHE_STATS_EN
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;

  // Saturating load hit/miss counters, only counted from IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_load_hit && (r_hit_cnt != {CNT_W{1'b1}}))
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      if (w_miss_start && (r_miss_cnt != {CNT_W{1'b1}}))
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_cache_controller;
  localparam int BW = 4;
  localparam int CW = 4;
  localparam int IW = $clog2(BW);
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic MemRead = 1'b0, MemWrite = 1'b0, hit = 1'b0, mem_ready = 1'b0;
  logic stall, mem_rd, mem_wr, cache_we, cache_valid_set;
  logic [IW-1:0] word_idx;
`ifdef CACHE_STATS_EN
  logic [CW-1:0] hit_cnt, miss_cnt;
`endif

  cache_controller #(.BLOCK_WORDS(BW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead(MemRead), .MemWrite(MemWrite), .hit(hit), .mem_ready(mem_ready),
    .stall(stall), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .cache_we(cache_we), .cache_valid_set(cache_valid_set),
`ifdef CACHE_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .word_idx(word_idx)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;

  // Reference model: what is outstanding, not how the FSM encodes it
  int m_words_left;   // refill words still to fetch (0 = no refill)
  int m_wr_pend;      // a store is waiting for memory
  int m_wr_hit;       // that store hit in the cache
  int m_retire;       // next cycle is the unstalled retire cycle
  int m_hits, m_misses;

  int seen_stall, seen_rd, seen_wr, seen_we, seen_vs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    m_words_left = 0; m_wr_pend = 0; m_wr_hit = 0; m_retire = 0;
    m_hits = 0; m_misses = 0;
  endtask

  task automatic clear_seen();
    seen_stall = 0; seen_rd = 0; seen_wr = 0; seen_we = 0; seen_vs = 0;
  endtask

  // One clock: drive inputs, check outputs at negedge, advance model at posedge
  task automatic step(input logic mr, input logic mw, input logic h, input logic rdy);
    int e_stall, e_rd, e_wr, e_we, e_vs, e_idx;
    MemRead = mr; MemWrite = mw; hit = h; mem_ready = rdy;
    @(negedge clk);
    e_stall = 0; e_rd = 0; e_wr = 0; e_we = 0; e_vs = 0; e_idx = 0;
    if (m_retire != 0) begin
      e_stall = 0;
    end else if (m_words_left > 0) begin
      e_stall = 1; e_rd = 1;
      e_idx = BW - m_words_left;
      e_we = int'(rdy);
      e_vs = (rdy && m_words_left == 1) ? 1 : 0;
    end else if (m_wr_pend != 0) begin
      e_stall = 1; e_wr = 1;
      e_we = (rdy && m_wr_hit != 0) ? 1 : 0;
    end else begin
      e_stall = (mw || (mr && !h)) ? 1 : 0;
    end
    chk("stall", 32'(stall), e_stall);
    chk("mem_rd", 32'(mem_rd), e_rd);
    chk("mem_wr", 32'(mem_wr), e_wr);
    chk("cache_we", 32'(cache_we), e_we);
    chk("cache_valid_set", 32'(cache_valid_set), e_vs);
    chk("word_idx", 32'(word_idx), e_idx);
`ifdef CACHE_STATS_EN
    chk("hit_cnt", 32'(hit_cnt), m_hits);
    chk("miss_cnt", 32'(miss_cnt), m_misses);
`endif
    seen_stall += int'(stall); seen_rd += int'(mem_rd); seen_wr += int'(mem_wr);
    seen_we += int'(cache_we); seen_vs += int'(cache_valid_set);
    @(posedge clk);
    if (m_retire != 0) begin
      m_retire = 0;
    end else if (m_words_left > 0) begin
      if (rdy) begin
        m_words_left--;
        if (m_words_left == 0) m_retire = 1;
      end
    end else if (m_wr_pend != 0) begin
      if (rdy) begin
        m_wr_pend = 0;
        m_retire = 1;
      end
    end else if (mw) begin
      m_wr_pend = 1;
      m_wr_hit = int'(h);
    end else if (mr && !h) begin
      m_words_left = BW;
      m_misses = sat(m_misses + 1);
    end else if (mr && h) begin
      m_hits = sat(m_hits + 1);
    end
    #1;
  endtask

  task automatic load_miss(input int n_wait);
    clear_seen();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < BW; w++) begin
      for (int k = 0; k < n_wait; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("miss_stall_cycles", seen_stall, 1 + BW * (n_wait + 1));
    chk("miss_we_pulses", seen_we, BW);
    chk("miss_valid_set", seen_vs, 1);
  endtask

  task automatic store(input int n_wait, input logic h);
    clear_seen();
    step(1'b0, 1'b1, h, 1'b0);
    for (int k = 0; k < n_wait; k++) step(1'b0, 1'b1, h, 1'b0);
    step(1'b0, 1'b1, h, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("store_stall_cycles", seen_stall, 2 + n_wait);
    chk("store_mem_wr_cycles", seen_wr, n_wait + 1);
    chk("store_we", seen_we, int'(h));
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_cache_we", 32'(cache_we), 0);
    chk("rst_valid_set", 32'(cache_valid_set), 0);
    chk("rst_word_idx", 32'(word_idx), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Load hits: zero penalty
    clear_seen();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'($urandom_range(1)));
    chk("hit_stall_total", seen_stall, 0);
    chk("hit_mem_rd_total", seen_rd, 0);

    // Load misses with 0 and 2 wait cycles per word, then back-to-back store
    load_miss(0);
    load_miss(2);
    store(2, 1'b1);
    store(1, 1'b0);
    // Both strobes high: store takes priority
    clear_seen();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("priority_mem_rd", seen_rd, 0);

    // Reset during refill word 2 abandons the transfer
    clear_seen();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_word_idx", 32'(word_idx), 2);
    MemRead = 1'b0; hit = 1'b0; mem_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_word_idx", 32'(word_idx), 0);
    chk("midrst_mem_rd", 32'(mem_rd), 0);
    chk("midrst_valid_set_total", seen_vs + int'(cache_valid_set), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    load_miss(1);

    // Enough hits and misses to saturate the statistics counters
    for (int i = 0; i < CMAX + 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < CMAX + 2; i++) load_miss(0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(1)), 1'($urandom_range(3) == 0),
           1'($urandom_range(1)), 1'($urandom_range(2) == 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
